predictor_gshare: RTL and testbench
===================================

Name: predictor_gshare

Overview:
- Parametrised successor to the fixed 2-bit branch predictor that sits between decode (prediction) and execute (resolution/update).
- Table of 2^INDEX_BITS saturating counters, indexed by PC, or by PC XOR global history (gshare).
- Speculative global history is repaired on mispredict.
- Saturating prediction and mispredict statistics counters are exposed for performance measurement.

Parameters:
- PC_WIDTH, 32: width of pc and past_pc.
- INDEX_BITS, 6: log2 of table entries.
- HIST_BITS, 6: global history length; legal range 1..INDEX_BITS.
- CTR_BITS, 2: saturating counter width; legal range 1..4.
- MODE, 1: 0 = bimodal (history ignored), 1 = gshare.
- STAT_BITS, 16: width of each statistics counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  PC_WIDTH  pc of instruction in decode.
- is_branch  in  1  decode instruction is a branch.
- past_pc  in  PC_WIDTH  pc of branch resolving in execute.
- past_is_branch  in  1  execute instruction is a branch.
- past_predicted_taken  in  1  prediction previously issued for past_pc.
- past_wrong  in  1  execute detected a mispredict on past_pc.
- shouldTakeBranch  out  1  predict taken for the decode branch.
- predict_count  out  STAT_BITS  resolved branches since reset.
- mispredict_count  out  STAT_BITS  resolved mispredicts since reset.

Behaviour:
- State:
  - table[2^INDEX_BITS] of CTR_BITS counters.
  - spec_ghr[HIST_BITS]: speculative global history.
  - ret_ghr[HIST_BITS]: retired global history.
  - two STAT_BITS counters.
- Reset (async, active-high; all flops, table included):
  - every table entry = 2^(CTR_BITS-1)-1 (weakly not-taken; 2'b01 for CTR_BITS=2).
  - spec_ghr = ret_ghr = 0; stats = 0.
  - shouldTakeBranch therefore reads 0 during reset.
- Index:
  - pidx = pc[INDEX_BITS-1:0] XOR zero-extended spec_ghr.
  - uidx = past_pc[INDEX_BITS-1:0] XOR zero-extended ret_ghr.
  - With MODE=0, both indices are the pc bits only.
- Prediction (combinational, zero latency):
  - shouldTakeBranch = is_branch & table[pidx][CTR_BITS-1]; forced 0 when is_branch=0.
  - Reads the pre-edge table value; no bypass of a same-cycle update, even when pidx==uidx.
- Resolution (edge, only when past_is_branch=1):
  - actual = past_predicted_taken XOR past_wrong.
  - table[uidx]: increment if actual=1, saturating at 2^CTR_BITS-1; decrement if actual=0, saturating at 0.
  - ret_ghr <= {ret_ghr[HIST_BITS-2:0], actual}. For HIST_BITS=1 this is {actual}.
  - predict_count +1, saturating at all-ones (no wrap).
  - mispredict_count +1 if past_wrong, saturating at all-ones.
  - past_wrong is ignored when past_is_branch=0.
- Speculative history:
  - On an edge with is_branch=1 and no recovery: spec_ghr <= {spec_ghr[HIST_BITS-2:0], shouldTakeBranch}.
  - Recovery (past_is_branch & past_wrong):
    - spec_ghr <= {ret_ghr[HIST_BITS-2:0], actual}, i.e. the same value ret_ghr takes this edge.
    - Recovery has priority over a simultaneous decode shift; that decode branch is on the flushed path and its history bit is discarded.
  - Correct resolution with simultaneous decode branch: spec_ghr shifts by the decode prediction; ret_ghr shifts by actual, independently.
- Invariant: in-order resolve with no mispredict keeps ret_ghr equal to the spec_ghr value used at prediction time, so uidx equals the pidx used for that branch.
- Reset mid-operation: all state returns to reset values asynchronously; in-flight resolutions are lost, with no partial update.
- No stalls or handshakes: one prediction and one update per cycle, fully pipelined.

Test Plan:
- Reset, then is_branch=1, pc=5 -> shouldTakeBranch=0; both stats 0; is_branch=0 -> output 0.
- MODE=0, pc=3, two resolves (past_pc=3, predicted 0, wrong 1) -> counter 01->10->11; next predict of pc=3 -> 1; predict_count=2, mispredict_count=2.
- MODE=0, pc=3 counter at 11, three correct-taken resolves -> stays 11 (saturates). Three not-taken resolves -> reaches 00; a fourth -> stays 00.
- MODE=1, HIST_BITS=6: predict 3 branches at pc=0 with counter 01 -> spec_ghr=000000. Resolve first as taken-mispredict -> spec_ghr=ret_ghr=000001. Next predict at pc=1 indexes entry 0 (1 XOR 1).
- Same edge: is_branch=1 predicting taken, and past_is_branch=1, past_wrong=1 -> spec_ghr equals the new ret_ghr; decode bit dropped.
- STAT_BITS=4: 17 mispredicted resolves -> both counters hold 4'hF. Assert reset mid-run -> counters, table and history return to reset values before the next edge.

Source files
------------

// File: rtl/predictor_gshare.sv
// Gshare/bimodal branch predictor: a table of saturating counters indexed by PC,
// optionally XORed with speculative history, which is repaired from retired history on a mispredict.
module predictor_gshare #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 1,
  parameter int STAT_BITS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 is_branch,
  input  logic [PC_WIDTH-1:0]  past_pc,
  input  logic                 past_is_branch,
  input  logic                 past_predicted_taken,
  input  logic                 past_wrong,
  output logic                 shouldTakeBranch,
  output logic [STAT_BITS-1:0] predict_count,
  output logic [STAT_BITS-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]   tbl_q [ENTRIES];
  logic [CTR_BITS-1:0]   tbl_d [ENTRIES];
  logic [HIST_BITS-1:0]  spec_ghr_q, spec_ghr_d;
  logic [HIST_BITS-1:0]  ret_ghr_q, ret_ghr_d;
  logic [STAT_BITS-1:0]  predict_count_q, predict_count_d;
  logic [STAT_BITS-1:0]  mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] pidx, uidx;
  logic [CTR_BITS-1:0]   ctr_cur, ctr_next;
  logic [HIST_BITS-1:0]  ret_shift;
  logic                  actual;
  logic                  recover;

  generate
    if (PC_WIDTH > INDEX_BITS) begin : g_unused_pc
      logic unused_pc_hi;
      assign unused_pc_hi = ^{pc[PC_WIDTH-1:INDEX_BITS], past_pc[PC_WIDTH-1:INDEX_BITS]};
    end
  endgenerate

  always_comb begin
    pidx = pc[INDEX_BITS-1:0];
    uidx = past_pc[INDEX_BITS-1:0];
    if (MODE != 0) begin
      pidx = pc[INDEX_BITS-1:0] ^ INDEX_BITS'(spec_ghr_q);
      uidx = past_pc[INDEX_BITS-1:0] ^ INDEX_BITS'(ret_ghr_q);
    end
  end

  // Reads the pre-edge table only; a same-cycle update to the same entry is not forwarded.
  assign shouldTakeBranch = is_branch & tbl_q[pidx][CTR_BITS-1];

  assign actual    = past_predicted_taken ^ past_wrong;
  assign recover   = past_is_branch & past_wrong;
  assign ret_shift = HIST_BITS'({ret_ghr_q, actual});
  assign ctr_cur   = tbl_q[uidx];

  always_comb begin
    ctr_next = ctr_cur;
    if (actual) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
    end
  end

  always_comb begin
    tbl_d = tbl_q;
    if (past_is_branch) tbl_d[uidx] = ctr_next;
  end

  // Recovery wins over a same-edge decode shift: that decode branch is on the flushed path.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    ret_ghr_d  = ret_ghr_q;
    if (past_is_branch) ret_ghr_d = ret_shift;
    if (recover)
      spec_ghr_d = ret_shift;
    else if (is_branch)
      spec_ghr_d = HIST_BITS'({spec_ghr_q, shouldTakeBranch});
  end

  always_comb begin
    predict_count_d    = predict_count_q;
    mispredict_count_d = mispredict_count_q;
    if (past_is_branch && (predict_count_q != '1))
      predict_count_d = predict_count_q + 1'b1;
    if (recover && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CTR_INIT;
      spec_ghr_q         <= '0;
      ret_ghr_q          <= '0;
      predict_count_q    <= '0;
      mispredict_count_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= tbl_d[i];
      spec_ghr_q         <= spec_ghr_d;
      ret_ghr_q          <= ret_ghr_d;
      predict_count_q    <= predict_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign predict_count    = predict_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_predictor_gshare.sv
// Directed bench for predictor_gshare: a bimodal/4-bit-stat instance and a gshare instance
// share stimulus; expected values are queued per step and drained against the outputs.
module tb_predictor_gshare;

  logic        clock, reset;
  logic [31:0] pc, past_pc;
  logic        is_branch, past_is_branch, past_predicted_taken, past_wrong;
  logic        b_take, g_take;
  logic [3:0]  b_pcnt, b_mcnt;
  logic [15:0] g_pcnt, g_mcnt;

  predictor_gshare #(.PC_WIDTH(32), .INDEX_BITS(6), .HIST_BITS(6), .CTR_BITS(2),
                     .MODE(0), .STAT_BITS(4)) dut_b (
    .clock(clock), .reset(reset), .pc(pc), .is_branch(is_branch),
    .past_pc(past_pc), .past_is_branch(past_is_branch),
    .past_predicted_taken(past_predicted_taken), .past_wrong(past_wrong),
    .shouldTakeBranch(b_take), .predict_count(b_pcnt), .mispredict_count(b_mcnt));

  predictor_gshare #(.PC_WIDTH(32), .INDEX_BITS(6), .HIST_BITS(6), .CTR_BITS(2),
                     .MODE(1), .STAT_BITS(16)) dut_g (
    .clock(clock), .reset(reset), .pc(pc), .is_branch(is_branch),
    .past_pc(past_pc), .past_is_branch(past_is_branch),
    .past_predicted_taken(past_predicted_taken), .past_wrong(past_wrong),
    .shouldTakeBranch(g_take), .predict_count(g_pcnt), .mispredict_count(g_mcnt));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  localparam int B_TAKE = 0, B_PC = 1, B_MC = 2, G_TAKE = 3, G_PC = 4, G_MC = 5,
                 G_SPEC = 6, G_RET = 7, B_TBL3 = 8;

  function automatic logic [15:0] observe(int sel);
    case (sel)
      B_TAKE:  return 16'(b_take);
      B_PC:    return 16'(b_pcnt);
      B_MC:    return 16'(b_mcnt);
      G_TAKE:  return 16'(g_take);
      G_PC:    return g_pcnt;
      G_MC:    return g_mcnt;
      G_SPEC:  return 16'(dut_g.spec_ghr_q);
      G_RET:   return 16'(dut_g.ret_ghr_q);
      B_TBL3:  return 16'(dut_b.tbl_q[3]);
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [15:0] obs;
    #1;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic ib, input logic [31:0] p, input logic pib,
                       input logic [31:0] pp, input logic ppt, input logic pw);
    is_branch = ib; pc = p; past_is_branch = pib; past_pc = pp;
    past_predicted_taken = ppt; past_wrong = pw;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(1, 5, 0, 0, 0, 0);
    push("in_reset_take_b", B_TAKE, 0);
    push("in_reset_take_g", G_TAKE, 0);
    check();

    reset = 1'b0;
    push("rst_take_pc5_b", B_TAKE, 0);
    push("rst_take_pc5_g", G_TAKE, 0);
    push("rst_pcnt_b", B_PC, 0);
    push("rst_mcnt_b", B_MC, 0);
    push("rst_pcnt_g", G_PC, 0);
    push("rst_mcnt_g", G_MC, 0);
    check();
    drive(0, 5, 0, 0, 0, 0);
    push("nobranch_take_b", B_TAKE, 0);
    push("nobranch_take_g", G_TAKE, 0);
    check();

    // Two taken mispredicts at pc=3: bimodal entry 01->10->11.
    drive(0, 0, 1, 3, 0, 1);
    tick(); tick();
    drive(1, 3, 0, 0, 0, 0);
    push("bim_take_after_up", B_TAKE, 1);
    push("bim_pcnt_2", B_PC, 2);
    push("bim_mcnt_2", B_MC, 2);
    push("gs_take_pc3_hist3", G_TAKE, 0);
    push("gs_pcnt_2", G_PC, 2);
    push("gs_mcnt_2", G_MC, 2);
    push("gs_spec_recovered", G_SPEC, 3);
    push("gs_ret_11", G_RET, 3);
    check();

    drive(0, 0, 1, 3, 1, 0);
    tick(); tick(); tick();
    drive(1, 3, 0, 0, 0, 0);
    push("bim_sat_hi_take", B_TAKE, 1);
    push("bim_sat_hi_tbl", B_TBL3, 3);
    push("bim_pcnt_5", B_PC, 5);
    push("bim_mcnt_still_2", B_MC, 2);
    push("gs_spec_held", G_SPEC, 3);
    push("gs_ret_011111", G_RET, 16'h1f);
    check();

    drive(0, 0, 1, 3, 0, 0);
    tick(); tick(); tick();
    drive(1, 3, 0, 0, 0, 0);
    push("bim_down_take", B_TAKE, 0);
    push("bim_down_tbl", B_TBL3, 0);
    push("bim_pcnt_8", B_PC, 8);
    check();
    drive(0, 0, 1, 3, 0, 0);
    tick();
    drive(1, 3, 0, 0, 0, 0);
    push("bim_sat_lo_take", B_TAKE, 0);
    push("bim_sat_lo_tbl", B_TBL3, 0);
    push("bim_pcnt_9", B_PC, 9);
    push("gs_ret_110000", G_RET, 16'h30);
    push("gs_pcnt_9", G_PC, 9);
    push("gs_mcnt_still_2", G_MC, 2);
    check();

    // 17 more mispredicts: 4-bit stats saturate, 16-bit stats keep counting.
    drive(0, 0, 1, 3, 0, 1);
    repeat (17) tick();
    drive(1, 3, 0, 0, 0, 0);
    push("stat_sat_pcnt_b", B_PC, 16'hf);
    push("stat_sat_mcnt_b", B_MC, 16'hf);
    push("stat_pcnt_g", G_PC, 26);
    push("stat_mcnt_g", G_MC, 19);
    push("pre_reset_take_b", B_TAKE, 1);
    check();

    // Asynchronous reset between edges, then held across an edge with a resolve pending.
    reset = 1'b1;
    push("midrst_take_b", B_TAKE, 0);
    push("midrst_tbl_b", B_TBL3, 1);
    push("midrst_pcnt_b", B_PC, 0);
    push("midrst_mcnt_b", B_MC, 0);
    push("midrst_pcnt_g", G_PC, 0);
    push("midrst_mcnt_g", G_MC, 0);
    push("midrst_spec_g", G_SPEC, 0);
    push("midrst_ret_g", G_RET, 0);
    check();
    drive(1, 3, 1, 3, 0, 1);
    tick();
    push("rsthold_tbl_b", B_TBL3, 1);
    push("rsthold_pcnt_g", G_PC, 0);
    push("rsthold_ret_g", G_RET, 0);
    check();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Gshare: three not-taken predictions at pc=0 leave history at zero.
    drive(1, 0, 0, 0, 0, 0);
    push("gs_pred1_pc0", G_TAKE, 0);
    check();
    tick();
    push("gs_pred2_pc0", G_TAKE, 0);
    check();
    tick();
    push("gs_pred3_pc0", G_TAKE, 0);
    check();
    tick();
    drive(0, 0, 1, 0, 0, 1);
    push("gs_spec_after3", G_SPEC, 0);
    check();
    tick();
    drive(1, 1, 0, 0, 0, 0);
    push("gs_spec_000001", G_SPEC, 1);
    push("gs_ret_000001", G_RET, 1);
    push("gs_pc1_hits_entry0", G_TAKE, 1);
    push("bim_pc1_ignores_hist", B_TAKE, 0);
    push("gs_pcnt_1", G_PC, 1);
    push("gs_mcnt_1", G_MC, 1);
    check();

    // Same edge: decode predicts taken while execute recovers with actual=0.
    drive(1, 1, 1, 0, 1, 1);
    push("gs_same_edge_take", G_TAKE, 1);
    check();
    tick();
    drive(1, 2, 1, 5, 0, 0);
    push("gs_recover_spec", G_SPEC, 2);
    push("gs_recover_ret", G_RET, 2);
    push("gs_recover_pcnt", G_PC, 2);
    push("gs_recover_mcnt", G_MC, 2);
    push("gs_pc2_take", G_TAKE, 1);
    check();
    // Correct resolve alongside a taken decode: histories shift independently.
    tick();
    drive(0, 0, 0, 0, 0, 0);
    push("gs_indep_spec", G_SPEC, 5);
    push("gs_indep_ret", G_RET, 4);
    push("gs_indep_pcnt", G_PC, 3);
    push("gs_indep_mcnt", G_MC, 2);
    check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
